// File: rtl/filter_pkg.sv
// Shared types and preset kernels for the image-filter datapath: FSM states,
// 3x3 preset tables, slot indices and a preset lookup used at reset.
package filter_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  localparam int SLOT_LAPLACIAN = 0;
  localparam int SLOT_SOBEL_X   = 1;
  localparam int SLOT_SOBEL_Y   = 2;
  localparam int SLOT_IDENTITY  = 3;

  localparam int LAPLACIAN_3x3 [9] = '{0, -1, 0, -1, 4, -1, 0, -1, 0};
  localparam int SOBEL_X_3x3   [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  localparam int SOBEL_Y_3x3   [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
  localparam int IDENTITY_3x3  [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};

  // Non-3x3 kernels and unlisted slots fall back to a centred identity.
  function automatic int preset_tap(input int slot, input int idx, input int ksize);
    int r;
    r = (idx == (ksize * ksize) / 2) ? 1 : 0;
    if (ksize == 3 && idx >= 0 && idx < 9) begin
      case (slot)
        SLOT_LAPLACIAN: r = LAPLACIAN_3x3[idx[3:0]];
        SLOT_SOBEL_X:   r = SOBEL_X_3x3[idx[3:0]];
        SLOT_SOBEL_Y:   r = SOBEL_Y_3x3[idx[3:0]];
        default:        r = IDENTITY_3x3[idx[3:0]];
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/kernel_coeff_bank.sv
// Coefficient storage with reset presets and one asynchronous read port.
// KERNEL_WRITE_EN enables the write port; otherwise storage is a constant table.
import filter_pkg::*;

module kernel_coeff_bank #(
  parameter int COEF_W      = 9,
  parameter int KSIZE       = 3,
  parameter int NUM_KERNELS = 4,
  localparam int N  = KSIZE * KSIZE,
  localparam int KW = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1,
  localparam int AW = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [KW-1:0]            wr_kernel,
  input  logic [AW-1:0]            wr_addr,
  input  logic signed [COEF_W-1:0] wr_data,
  input  logic [KW-1:0]            rd_kernel,
  input  logic [AW-1:0]            rd_addr,
  output logic signed [COEF_W-1:0] rd_data
);

  logic rd_ok;
  assign rd_ok = (int'(rd_kernel) < NUM_KERNELS) && (int'(rd_addr) < N);

`ifdef KERNEL_WRITE_EN
  logic signed [COEF_W-1:0] mem [NUM_KERNELS][N];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_KERNELS; k++)
        for (int a = 0; a < N; a++)
          mem[k][a] <= COEF_W'(preset_tap(k, a, KSIZE));
    end else if (wr_en && int'(wr_kernel) < NUM_KERNELS && int'(wr_addr) < N) begin
      mem[wr_kernel][wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_ok) rd_data = mem[rd_kernel][rd_addr];
  end
`else
  // Read-only build: the table folds into constant logic.
  logic unused_wr;
  assign unused_wr = ^{clk, reset, wr_en, wr_kernel, wr_addr, wr_data};

  always_comb begin
    rd_data = '0;
    if (rd_ok) rd_data = COEF_W'(preset_tap(int'(rd_kernel), int'(rd_addr), KSIZE));
  end
`endif

endmodule

// File: rtl/kernel_coeff_streamer.sv
// Streams one selected kernel's taps in raster order over valid/ready and
// reports the tap sum with a done pulse. Write port active with KERNEL_WRITE_EN.
import filter_pkg::*;

module kernel_coeff_streamer #(
  parameter int COEF_W      = 9,
  parameter int KSIZE       = 3,
  parameter int NUM_KERNELS = 4,
  localparam int N  = KSIZE * KSIZE,
  localparam int KW = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1,
  localparam int AW = $clog2(N),
  localparam int SW = COEF_W + AW + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [KW-1:0]            kernel_sel,
  output logic                     busy,
  output logic                     coef_valid,
  input  logic                     coef_ready,
  output logic signed [COEF_W-1:0] coef_data,
  output logic [AW-1:0]            coef_idx,
  output logic                     coef_last,
  output logic                     done,
  output logic signed [SW-1:0]     coef_sum,
  input  logic                     wr_en,
  input  logic [KW-1:0]            wr_kernel,
  input  logic [AW-1:0]            wr_addr,
  input  logic signed [COEF_W-1:0] wr_data
);

  function automatic logic signed [SW-1:0] sext(input logic signed [COEF_W-1:0] v);
    return SW'(v);
  endfunction

  state_t                   state_q, state_d;
  logic [KW-1:0]            sel_p0;
  logic [KW-1:0]            rd_kernel;
  logic [AW-1:0]            rd_addr;
  logic signed [COEF_W-1:0] rd_data;
  logic                     accept;

  assign accept = coef_valid & coef_ready;

  // Next tap is read from pre-edge storage, so same-edge writes are not seen.
  assign rd_kernel = (state_q == IDLE) ? kernel_sel : sel_p0;
  assign rd_addr   = (state_q == IDLE) ? '0 : coef_idx + AW'(1);

  kernel_coeff_bank #(
    .COEF_W(COEF_W), .KSIZE(KSIZE), .NUM_KERNELS(NUM_KERNELS)
  ) u_bank (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_kernel(wr_kernel), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_kernel(rd_kernel), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (accept && coef_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: state, handshake outputs and accumulator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sel_p0     <= '0;
      busy       <= 1'b0;
      coef_valid <= 1'b0;
      done       <= 1'b0;
      coef_data  <= '0;
      coef_idx   <= '0;
      coef_last  <= 1'b0;
      coef_sum   <= '0;
    end else begin
      state_q    <= state_d;
      busy       <= (state_d != IDLE);
      coef_valid <= (state_d == STREAM);
      done       <= (state_d == DONE);
      if (state_q == IDLE && start) begin
        sel_p0    <= kernel_sel;
        coef_data <= rd_data;
        coef_idx  <= '0;
        coef_last <= (N == 1);
        coef_sum  <= '0;
      end else if (state_q == STREAM && accept) begin
        coef_sum <= coef_sum + sext(coef_data);
        if (!coef_last) begin
          coef_data <= rd_data;
          coef_idx  <= coef_idx + AW'(1);
          coef_last <= (coef_idx + AW'(1) == AW'(N - 1));
        end
      end
    end
  end

endmodule

// File: tb/tb_kernel_coeff_streamer.sv
// Scoreboard bench for kernel_coeff_streamer; follows KERNEL_WRITE_EN for the
// write-port model so it matches either build.
module tb_kernel_coeff_streamer;

  localparam int COEF_W = 9, KSIZE = 3, NUM_KERNELS = 4;
  localparam int N = 9, KW = 2, AW = 4, SW = 14;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, coef_ready = 1'b0, wr_en = 1'b0;
  logic [KW-1:0] kernel_sel = '0, wr_kernel = '0;
  logic [AW-1:0] wr_addr = '0;
  logic signed [COEF_W-1:0] wr_data = '0;
  logic busy, coef_valid, coef_last, done;
  logic signed [COEF_W-1:0] coef_data;
  logic [AW-1:0] coef_idx;
  logic signed [SW-1:0] coef_sum;

  kernel_coeff_streamer #(.COEF_W(COEF_W), .KSIZE(KSIZE), .NUM_KERNELS(NUM_KERNELS)) dut (
    .clk(clk), .reset(reset), .start(start), .kernel_sel(kernel_sel), .busy(busy),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
    .coef_idx(coef_idx), .coef_last(coef_last), .done(done), .coef_sum(coef_sum),
    .wr_en(wr_en), .wr_kernel(wr_kernel), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {int data; int idx; int last;} tap_t;
  tap_t exp_q[$];
  int   sum_q[$];
  int   model [NUM_KERNELS][N];
  int   checks = 0, failures = 0, done_cnt = 0, tap_cnt = 0, stream_slot = -1;
  int   rmode = 0, rcyc = 0;
  logic prev_stall = 1'b0;
  int   prev_data = 0, prev_idx = 0;
  tap_t mon_t;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int preset(input int s, input int a);
    int lap [9] = '{0, -1, 0, -1, 4, -1, 0, -1, 0};
    int sx  [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    int sy  [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    case (s)
      0:       return lap[a];
      1:       return sx[a];
      2:       return sy[a];
      default: return (a == 4) ? 1 : 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_KERNELS; k++)
      for (int a = 0; a < N; a++) model[k][a] = preset(k, a);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rmode == 1) begin
      coef_ready = (rcyc % 4 == 0) || (rcyc % 4 == 3);
      rcyc++;
    end
  endtask

  task automatic push_expected(input int sel);
    int s = 0;
    for (int a = 0; a < N; a++) begin
      int d = (sel < NUM_KERNELS) ? model[sel][a] : 0;
      exp_q.push_back('{d, a, (a == N - 1) ? 1 : 0});
      s += d;
    end
    sum_q.push_back(s);
    tap_cnt = 0;
    stream_slot = sel;
  endtask

  // Tap at the queue head is already loaded; later taps of the active kernel pick up the write.
  task automatic apply_write(input int k, input int a, input int d);
`ifdef KERNEL_WRITE_EN
    if (k < NUM_KERNELS && a < N) begin
      model[k][a] = d;
      if (k == stream_slot && exp_q.size() > 0)
        for (int i = 1; i < exp_q.size(); i++)
          if (exp_q[i].idx == a) begin
            tap_t t = exp_q[i];
            sum_q[sum_q.size() - 1] += d - t.data;
            t.data = d;
            exp_q[i] = t;
          end
    end
`else
    if (k < 0 || a < 0 || d > 9999) $display("note: write ignored in read-only build");
`endif
  endtask

  task automatic do_write(input int k, input int a, input int d);
    wr_en = 1'b1; wr_kernel = KW'(k); wr_addr = AW'(a); wr_data = COEF_W'(d);
    apply_write(k, a, d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_stream(input int sel);
    push_expected(sel);
    kernel_sel = KW'(sel);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 100 && done_cnt < target; i++) tick();
    check_eq("done_count", done_cnt, target);
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_valid"}, int'(coef_valid), 0);
    check_eq({tag, "_busy"}, int'(busy), 0);
    check_eq({tag, "_done"}, int'(done), 0);
    check_eq({tag, "_data"}, int'(coef_data), 0);
    check_eq({tag, "_idx"}, int'(coef_idx), 0);
    check_eq({tag, "_last"}, int'(coef_last), 0);
    check_eq({tag, "_sum"}, int'(coef_sum), 0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (prev_stall) begin
        check_eq("hold_data", int'(coef_data), prev_data);
        check_eq("hold_idx", int'(coef_idx), prev_idx);
      end
      prev_stall = coef_valid && !coef_ready;
      prev_data  = int'(coef_data);
      prev_idx   = int'(coef_idx);
      if (coef_valid && coef_ready) begin
        if (exp_q.size() == 0) check_eq("unexpected_tap_idx", int'(coef_idx), -1);
        else begin
          mon_t = exp_q.pop_front();
          check_eq("tap_data", int'(coef_data), mon_t.data);
          check_eq("tap_idx", int'(coef_idx), mon_t.idx);
          check_eq("tap_last", int'(coef_last), mon_t.last);
          tap_cnt++;
        end
      end
      if (done) begin
        done_cnt++;
        check_eq("busy_in_done", int'(busy), 1);
        check_eq("valid_in_done", int'(coef_valid), 0);
        if (sum_q.size() == 0) check_eq("unexpected_done_sum", int'(coef_sum), -99999);
        else begin
          check_eq("coef_sum", int'(coef_sum), sum_q.pop_front());
          check_eq("taps_per_stream", tap_cnt, N);
        end
      end
    end else prev_stall = 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    check_idle_zero("reset");
    @(negedge clk) reset = 1'b1;
    coef_ready = 1'b1;
    tick();

    // Laplacian at full throughput
    start_stream(0);
    wait_done(1);

    // Sobel-X under a 1,0,0,1 ready pattern
    rmode = 1; rcyc = 0;
    start_stream(1);
    wait_done(2);
    rmode = 0; coef_ready = 1'b1;

    // centre rewrite of identity, plus an out-of-range write that must drop
    do_write(3, 4, -7);
    do_write(1, 9, 33);
    start_stream(3);
    wait_done(3);

    // writes while idx 2 of Sobel-Y is stalled
    start_stream(2);
    for (int i = 0; i < 20 && coef_idx != 2; i++) tick();
    coef_ready = 1'b0;
    do_write(2, 2, 5);
    do_write(2, 6, 9);
    tick();
    coef_ready = 1'b1;
    wait_done(4);

    // write and start in the same cycle, then a start while busy
    push_expected(0);
    wr_en = 1'b1; wr_kernel = '0; wr_addr = '0; wr_data = 9'sd5;
    kernel_sel = '0; start = 1'b1;
    apply_write(0, 0, 5);
    tick();
    start = 1'b0; wr_en = 1'b0;
    tick(); tick();
    kernel_sel = 2'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(5);
    start_stream(3);
    wait_done(6);

    // reset mid-stream at idx 4
    start_stream(0);
    for (int i = 0; i < 20 && coef_idx != 4; i++) tick();
    #2 reset = 1'b0;
    #1 check_idle_zero("abort");
    exp_q.delete();
    sum_q.delete();
    model_reset();
    tick(); tick();
    @(negedge clk) reset = 1'b1;
    tick();
    check_eq("no_done_after_abort", done_cnt, 6);
    start_stream(0);
    wait_done(7);

    tick(); tick();
    check_eq("leftover_taps", exp_q.size(), 0);
    check_eq("final_done_count", done_cnt, 7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
